// File: rtl/tx_frame_buffer.sv
// tx_frame_buffer
// Store-and-forward AXI-Stream frame buffer placed directly upstream of a
// 32-bit TX MAC. A frame is only released once its tlast beat is stored, so
// the MAC sees tvalid held high from the first word to tlast. A frame that
// does not fit is discarded whole and reported on frame_drop.
//
// Build option: define TX_FRAME_BUF_KEEP_CHECK_EN to also discard frames
// whose tkeep pattern is malformed (partial keep before tlast, or an empty or
// non-contiguous keep on tlast). Without it, tkeep is stored and forwarded
// unmodified.
module tx_frame_buffer #(
  parameter int DEPTH = 512
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [31:0]              s00_axis_tdata,
  input  logic [3:0]               s00_axis_tkeep,
  input  logic                     s00_axis_tvalid,
  output logic                     s00_axis_tready,
  input  logic                     s00_axis_tlast,
  output logic [31:0]              m00_axis_tdata,
  output logic [3:0]               m00_axis_tkeep,
  output logic                     m00_axis_tvalid,
  input  logic                     m00_axis_tready,
  output logic                     m00_axis_tlast,
  output logic [$clog2(DEPTH):0]   frame_count,
  output logic                     frame_drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [PW-1:0] PTR_DEPTH = PW'(DEPTH);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } rd_state_t;

`ifdef TX_FRAME_BUF_KEEP_CHECK_EN
  // Malformed keep: anything but all-ones mid-frame, or a non-contiguous /
  // empty pattern on the last beat.
  function automatic logic keep_bad(input logic last, input logic [3:0] keep);
    logic bad;
    if (!last) begin
      bad = (keep != 4'b1111);
    end else begin
      case (keep)
        4'b0001, 4'b0011, 4'b0111, 4'b1111: bad = 1'b0;
        default:                            bad = 1'b1;
      endcase
    end
    return bad;
  endfunction
`endif

  // Storage: {tlast, tkeep, tdata}
  logic [36:0]     r_mem [DEPTH];
  logic [36:0]     r_ram_q;
  logic            r_ram_vld;

  // Pointers carry one extra MSB so full and empty are distinguishable.
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_commit_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [PW-1:0]   r_frame_count;
  logic            r_dropping;
  logic            r_frame_drop;
  logic            r_tready;

  // Output register plus one-entry skid.
  logic [31:0]     r_m_data;
  logic [3:0]      r_m_keep;
  logic            r_m_last;
  logic            r_m_vld;
  logic [36:0]     r_sk_q;
  logic            r_sk_vld;

  rd_state_t       r_state;
  rd_state_t       w_next_state;

  logic            w_accept;
  logic [PW-1:0]   w_fill;
  logic            w_full;
  logic            w_bad_beat;
  logic            w_discard;
  logic            w_wr_en;
  logic            w_commit;
  logic            w_drop_end;
  logic            w_pop;
  logic            w_release;
  logic [2:0]      w_occ;
  logic            w_space;
  logic            w_avail;
  logic            w_rd_en;

  assign w_accept   = s00_axis_tvalid & r_tready;
  assign w_fill     = r_wr_ptr - r_rd_ptr;
  assign w_full     = (w_fill == PTR_DEPTH);
`ifdef TX_FRAME_BUF_KEEP_CHECK_EN
  assign w_bad_beat = keep_bad(s00_axis_tlast, s00_axis_tkeep);
`else
  assign w_bad_beat = 1'b0;
`endif
  // A beat is thrown away if the frame is already being dropped, the buffer
  // is full, or the beat itself is malformed.
  assign w_discard  = w_accept & (r_dropping | w_full | w_bad_beat);
  assign w_wr_en    = w_accept & ~w_discard;
  assign w_commit   = w_wr_en & s00_axis_tlast;
  assign w_drop_end = w_discard & s00_axis_tlast;

  assign w_pop      = r_m_vld & m00_axis_tready;
  assign w_release  = w_pop & r_m_last;
  // Words held in the output register, the skid and the RAM read in flight.
  // A new read is allowed only if its word is guaranteed a free slot even
  // if the MAC stalls on the next cycle.
  assign w_occ      = {2'b00, r_m_vld} + {2'b00, r_sk_vld} + {2'b00, r_ram_vld};
  assign w_space    = (w_occ <= (3'd1 + {2'b00, w_pop}));
  // rd_ptr never passes commit_ptr, so only whole stored frames are read.
  assign w_avail    = (r_rd_ptr != r_commit_ptr);

  // Write side: accept every beat, write or discard it, commit on tlast and
  // rewind over a dropped frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tready     <= 1'b0;
      r_wr_ptr     <= '0;
      r_commit_ptr <= '0;
      r_dropping   <= 1'b0;
      r_frame_drop <= 1'b0;
    end else begin
      r_tready     <= 1'b1;
      r_frame_drop <= w_drop_end;
      if (w_drop_end) begin
        r_wr_ptr   <= r_commit_ptr;
        r_dropping <= 1'b0;
      end else if (w_discard) begin
        r_dropping <= 1'b1;
      end else if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
        if (s00_axis_tlast) begin
          r_commit_ptr <= r_wr_ptr + PTR_ONE;
        end
      end
    end
  end

  // RAM write port.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr[AW-1:0]] <= {s00_axis_tlast, s00_axis_tkeep, s00_axis_tdata};
    end
  end

  // RAM synchronous read port.
  always_ff @(posedge clk) begin
    if (w_rd_en) begin
      r_ram_q <= r_mem[r_rd_ptr[AW-1:0]];
    end
  end

  // Stored-frame counter: commit and release in one cycle cancel out.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_frame_count <= '0;
    end else begin
      case ({w_commit, w_release})
        2'b10:   r_frame_count <= r_frame_count + PTR_ONE;
        2'b01:   r_frame_count <= r_frame_count - PTR_ONE;
        default: r_frame_count <= r_frame_count;
      endcase
    end
  end

  // Read FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Read FSM next state and RAM read enable.
  always_comb begin
    w_next_state = r_state;
    w_rd_en      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if ((r_frame_count != '0) && w_avail) begin
          w_next_state = ST_STREAM;
          w_rd_en      = w_space;
        end else begin
          w_next_state = ST_IDLE;
          w_rd_en      = 1'b0;
        end
      end
      ST_STREAM: begin
        // Keep reading ahead, straight into the next committed frame.
        w_rd_en = w_avail & w_space;
        if (w_release && !w_avail && !r_ram_vld && !r_sk_vld) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_STREAM;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
        w_rd_en      = 1'b0;
      end
    endcase
  end

  // Read pointer and read-in-flight flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_ptr  <= '0;
      r_ram_vld <= 1'b0;
    end else begin
      r_ram_vld <= w_rd_en;
      if (w_rd_en) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
    end
  end

  // Output register and skid: the skid absorbs a word arriving from the RAM
  // while the output is stalled, so nothing in flight is ever overwritten.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_m_data <= 32'h0000_0000;
      r_m_keep <= 4'b0000;
      r_m_last <= 1'b0;
      r_m_vld  <= 1'b0;
      r_sk_q   <= 37'h0;
      r_sk_vld <= 1'b0;
    end else if (!r_m_vld || w_pop) begin
      if (r_sk_vld) begin
        {r_m_last, r_m_keep, r_m_data} <= r_sk_q;
        r_m_vld  <= 1'b1;
        r_sk_vld <= r_ram_vld;
        if (r_ram_vld) begin
          r_sk_q <= r_ram_q;
        end
      end else if (r_ram_vld) begin
        {r_m_last, r_m_keep, r_m_data} <= r_ram_q;
        r_m_vld <= 1'b1;
      end else begin
        r_m_vld <= 1'b0;
      end
    end else if (r_ram_vld) begin
      r_sk_q   <= r_ram_q;
      r_sk_vld <= 1'b1;
    end
  end

  assign s00_axis_tready = r_tready;
  assign m00_axis_tdata  = r_m_data;
  assign m00_axis_tkeep  = r_m_keep;
  assign m00_axis_tlast  = r_m_last;
  assign m00_axis_tvalid = r_m_vld;
  assign frame_count     = r_frame_count;
  assign frame_drop      = r_frame_drop;

endmodule

// File: tb/tb_tx_frame_buffer.sv
// Bench for tx_frame_buffer (DEPTH=64): table of frames plus hand-written
// multi-cycle sequences; expected beats are queued when driven and checked
// as the MAC side accepts them.
`timescale 1ns/1ps
module tb_tx_frame_buffer;

  localparam int DEPTH = 64;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef TX_FRAME_BUF_KEEP_CHECK_EN
  localparam bit KEEP_CHK = 1'b1;
`else
  localparam bit KEEP_CHK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic [31:0]   s_tdata;
  logic [3:0]    s_tkeep;
  logic          s_tvalid;
  logic          s_tready;
  logic          s_tlast;
  logic [31:0]   m_tdata;
  logic [3:0]    m_tkeep;
  logic          m_tvalid;
  logic          m_tready;
  logic          m_tlast;
  logic [CW-1:0] frame_count;
  logic          frame_drop;

  always #5 clk = ~clk;

  tx_frame_buffer #(.DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .s00_axis_tdata  (s_tdata),
    .s00_axis_tkeep  (s_tkeep),
    .s00_axis_tvalid (s_tvalid),
    .s00_axis_tready (s_tready),
    .s00_axis_tlast  (s_tlast),
    .m00_axis_tdata  (m_tdata),
    .m00_axis_tkeep  (m_tkeep),
    .m00_axis_tvalid (m_tvalid),
    .m00_axis_tready (m_tready),
    .m00_axis_tlast  (m_tlast),
    .frame_count     (frame_count),
    .frame_drop      (frame_drop)
  );

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } beat_t;

  typedef struct {
    int          len;
    bit          bursty;
    logic [3:0]  last_keep;
    int          bad_idx;
    int          rdy_mode;
    int          exp_drops;
    int          exp_peak;
  } vec_t;

  beat_t exp_q[$];
  beat_t mon_e;
  vec_t  vt[8];

  int n_checks = 0;
  int n_pass   = 0;
  int rdy_mode = 0;
  int pop_cnt  = 0;
  int drop_cnt = 0;
  int gaps     = 0;
  int peak     = 0;
  int d0, base, wk, widle;
  bit in_frame   = 1'b0;
  bit prev_stall = 1'b0;
  bit prev_drop  = 1'b0;
  logic [37:0] prev_out;

  task automatic check(input bit ok, input string name, input string detail);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: %s", name, detail);
  endtask

  // MAC-side ready pattern generator.
  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       m_tready = 1'b1;
        1:       m_tready = ~m_tready;
        2:       m_tready = 1'($urandom_range(0, 1));
        default: m_tready = 1'b0;
      endcase
    end
  end

  // Output monitor: scoreboard compare, stall stability, in-frame gaps, drops.
  always @(negedge clk) begin
    if (reset_n) begin
      if (int'(frame_count) > peak) peak = int'(frame_count);
      if (prev_stall)
        check({m_tvalid, m_tlast, m_tkeep, m_tdata} == prev_out, "stall_hold",
              $sformatf("output %h changed while stalled, held value %h",
                        {m_tvalid, m_tlast, m_tkeep, m_tdata}, prev_out));
      prev_stall = m_tvalid && !m_tready;
      prev_out   = {m_tvalid, m_tlast, m_tkeep, m_tdata};
      if (in_frame && !m_tvalid) gaps++;
      if (frame_drop) begin
        drop_cnt++;
        check(!prev_drop, "drop_single", "frame_drop high two cycles in a row, required one-cycle pulse");
      end
      prev_drop = frame_drop;
      if (m_tvalid && m_tready) begin
        pop_cnt++;
        check(exp_q.size() != 0, "unexpected_beat",
              $sformatf("got data %h keep %b last %b with no beat expected", m_tdata, m_tkeep, m_tlast));
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check(m_tdata == mon_e.data && m_tkeep == mon_e.keep && m_tlast == mon_e.last, "out_beat",
                $sformatf("got %h/%b/%b required %h/%b/%b", m_tdata, m_tkeep, m_tlast,
                          mon_e.data, mon_e.keep, mon_e.last));
        end
        if (m_tlast) begin
          check(gaps == 0, "frame_gap", $sformatf("tvalid low %0d cycles inside frame, required 0", gaps));
          gaps     = 0;
          in_frame = 1'b0;
        end else begin
          in_frame = 1'b1;
        end
      end
    end else begin
      in_frame   = 1'b0;
      prev_stall = 1'b0;
      prev_drop  = 1'b0;
      gaps       = 0;
    end
  end

  task automatic drive_frame(input int len, input bit bursty, input logic [3:0] last_keep,
                             input int bad_idx, input bit exp_out, input bit hold_valid);
    logic [31:0] r;
    beat_t b;
    for (int i = 0; i < len; i++) begin
      if (bursty && i > 0) begin
        s_tvalid = 1'b0;
        @(posedge clk); #1;
      end
      r      = $urandom();
      b.data = {r[31:16], 16'(i)};
      b.keep = (i == len - 1) ? last_keep : ((i == bad_idx) ? 4'b0111 : 4'b1111);
      b.last = (i == len - 1);
      s_tdata  = b.data;
      s_tkeep  = b.keep;
      s_tlast  = b.last;
      s_tvalid = 1'b1;
      if (exp_out) exp_q.push_back(b);
      @(posedge clk); #1;
    end
    if (!hold_valid) begin
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
    end
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    repeat (3) @(negedge clk);
    while ((exp_q.size() != 0 || frame_count != 0 || m_tvalid) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check(k < 3000, name, $sformatf("drain timeout: %0d beats outstanding, frame_count %0d",
                                    exp_q.size(), frame_count));
    @(posedge clk); #1;
  endtask

  // Global watchdog.
  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //          len      bursty keep     bad  rdy drops       peak
    vt[0] = '{16,        1'b1, 4'b0011, -1,  0,  0,          1};
    vt[1] = '{70,        1'b0, 4'b1111, -1,  0,  1,          0};
    vt[2] = '{10,        1'b0, 4'b0001, -1,  0,  0,          1};
    vt[3] = '{20,        1'b0, 4'b1111,  2,  0,  KEEP_CHK ? 1 : 0, KEEP_CHK ? 0 : 1};
    vt[4] = '{1,         1'b0, 4'b0111, -1,  0,  0,          1};
    vt[5] = '{DEPTH,     1'b0, 4'b1111, -1,  1,  0,          1};
    vt[6] = '{DEPTH + 1, 1'b0, 4'b1111, -1,  0,  1,          0};
    vt[7] = '{12,        1'b0, 4'b0011, -1,  2,  0,          1};

    reset_n  = 1'b0;
    s_tdata  = 32'h0;
    s_tkeep  = 4'h0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check(s_tready == 1'b0, "rst_tready", $sformatf("got %b required 0", s_tready));
    check({m_tvalid, m_tlast, m_tkeep, m_tdata} == 38'h0, "rst_m_axis",
          $sformatf("got %h required 0", {m_tvalid, m_tlast, m_tkeep, m_tdata}));
    check(frame_count == 0 && frame_drop == 1'b0, "rst_count_drop",
          $sformatf("got count %0d drop %b required 0/0", frame_count, frame_drop));
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    check(s_tready == 1'b0, "tready_before_edge", $sformatf("got %b required 0", s_tready));
    @(negedge clk);
    check(s_tready == 1'b1, "tready_after_edge", $sformatf("got %b required 1", s_tready));
    @(posedge clk); #1;

    // Basic frame and commit-to-output latency.
    peak = 0;
    drive_frame(16, 1'b0, 4'b0011, -1, 1'b1, 1'b0);
    @(negedge clk);
    check(frame_count == 1, "basic_count", $sformatf("got %0d required 1", frame_count));
    check(m_tvalid == 1'b0, "lat_n0", $sformatf("got tvalid %b required 0", m_tvalid));
    @(negedge clk);
    check(m_tvalid == 1'b0, "lat_n1", $sformatf("got tvalid %b required 0", m_tvalid));
    @(negedge clk);
    check(m_tvalid == 1'b1, "lat_n2", $sformatf("got tvalid %b required 1", m_tvalid));
    drain("basic_drain");
    check(peak == 1, "basic_peak", $sformatf("got %0d required 1", peak));

    // Table-driven frames.
    for (int i = 0; i < 8; i++) begin
      rdy_mode = vt[i].rdy_mode;
      d0       = drop_cnt;
      peak     = 0;
      drive_frame(vt[i].len, vt[i].bursty, vt[i].last_keep, vt[i].bad_idx,
                  vt[i].exp_drops == 0, 1'b0);
      drain($sformatf("vec%0d_drain", i));
      check(drop_cnt - d0 == vt[i].exp_drops, $sformatf("vec%0d_drops", i),
            $sformatf("got %0d drop pulses required %0d", drop_cnt - d0, vt[i].exp_drops));
      check(peak == vt[i].exp_peak, $sformatf("vec%0d_peak", i),
            $sformatf("got frame_count peak %0d required %0d", peak, vt[i].exp_peak));
    end

    // Back-pressure: three back-to-back frames, ready toggling every cycle.
    rdy_mode = 1;
    base     = pop_cnt;
    fork
      begin
        drive_frame(15, 1'b0, 4'b1111, -1, 1'b1, 1'b1);
        drive_frame(15, 1'b0, 4'b1111, -1, 1'b1, 1'b1);
        drive_frame(15, 1'b0, 4'b0111, -1, 1'b1, 1'b0);
      end
      begin
        wk = 0;
        while (!m_tvalid && wk < 200) begin
          @(negedge clk); #1;
          wk++;
        end
        check(wk < 200, "bp_start", "tvalid never rose");
        wk    = 0;
        widle = 0;
        while (pop_cnt - base < 45 && wk < 500) begin
          @(negedge clk); #1;
          if (!m_tvalid) widle++;
          wk++;
        end
        check(pop_cnt - base >= 45, "bp_beats", $sformatf("got %0d beats required 45", pop_cnt - base));
        check(widle == 0, "bp_no_idle", $sformatf("got %0d idle cycles required 0", widle));
      end
    join
    drain("bp_drain");

    // Frame B's tlast accepted on the cycle frame A's tlast is output.
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    peak = 0;
    drive_frame(8, 1'b0, 4'b1111, -1, 1'b1, 1'b1);
    drive_frame(10, 1'b0, 4'b0011, -1, 1'b1, 1'b0);
    @(negedge clk);
    check(frame_count == 1, "sim_count", $sformatf("got %0d required 1", frame_count));
    drain("sim_drain");
    check(peak == 1, "sim_peak", $sformatf("got %0d required 1", peak));

    // Reset mid-operation: one stored frame and one partial frame are lost.
    rdy_mode = 3;
    repeat (2) @(posedge clk);
    #1;
    drive_frame(4, 1'b0, 4'b1111, -1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      s_tdata  = 32'hDEAD_0000 + 32'(i);
      s_tkeep  = 4'b1111;
      s_tlast  = 1'b0;
      s_tvalid = 1'b1;
      @(posedge clk); #1;
    end
    s_tvalid = 1'b0;
    @(negedge clk);
    check(frame_count == 1, "pre_reset_count", $sformatf("got %0d required 1", frame_count));
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(negedge clk);
    check(frame_count == 0 && m_tvalid == 1'b0 && s_tready == 1'b0, "mid_reset",
          $sformatf("got count %0d tvalid %b tready %b required 0/0/0", frame_count, m_tvalid, s_tready));
    @(posedge clk); #1;
    reset_n  = 1'b1;
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    peak = 0;
    drive_frame(6, 1'b0, 4'b0001, -1, 1'b1, 1'b0);
    drain("post_reset_drain");
    check(peak == 1, "post_reset_peak", $sformatf("got %0d required 1", peak));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tx_frame_buffer.md
# tx_frame_buffer

Store-and-forward AXI-Stream frame buffer that sits directly upstream of the 32-bit TX MAC. It accepts user frames at any rate, including with `tvalid` gaps. It releases a frame to the MAC only once the whole frame is stored, so `tvalid` stays high for every beat from first word to `tlast`, which the MAC requires. Frames that do not fit in the buffer are dropped whole, so a partial frame is never forwarded.

## Interface
- `DEPTH`, 512: buffer depth in 32-bit words; power of 2, minimum 32.
- `clk`  in  1  single clock for both sides.
- `reset_n`  in  1  asynchronous, active-low reset.
- `s00_axis_tdata`  in  32  user data, byte 0 in [7:0].
- `s00_axis_tkeep`  in  4  byte enables; contiguous from bit 0.
- `s00_axis_tvalid`  in  1  user beat valid.
- `s00_axis_tready`  out  1  buffer accepts a beat.
- `s00_axis_tlast`  in  1  last beat of frame.
- `m00_axis_tdata`  out  32  data to MAC.
- `m00_axis_tkeep`  out  4  byte enables to MAC.
- `m00_axis_tvalid`  out  1  beat valid to MAC.
- `m00_axis_tready`  in  1  MAC ready; may depend combinationally on PHY ready.
- `m00_axis_tlast`  out  1  last beat to MAC.
- `frame_count`  out  $clog2(DEPTH)+1  number of complete frames stored and not fully released.
- `frame_drop`  out  1  one-cycle pulse when an incoming frame is discarded.

## Operation
- **Storage:** DEPTH×37-bit simple dual-port RAM holding {tlast, tkeep, tdata}, with synchronous read.
- **Pointers:** `wr_ptr`, `commit_ptr` and `rd_ptr` are each $clog2(DEPTH)+1 bits. The extra MSB disambiguates full from empty. All pointers wrap modulo 2·DEPTH.
- **Write side:**
  - `s00_axis_tready` is 1 whenever out of reset; the buffer never back-pressures.
  - An accepted beat is written at `wr_ptr`, then `wr_ptr` increments.
  - Overflow occurs when an accepted beat arrives while `wr_ptr - rd_ptr == DEPTH`. The frame enters DROPPING.
  - In DROPPING, beats are accepted and discarded until `tlast`. `wr_ptr` is then rewound to `commit_ptr` and `frame_drop` pulses.
  - Any frame longer than DEPTH words is always dropped.
- **Commit:** when a `tlast` beat is accepted and not dropping, `commit_ptr <= wr_ptr+1` and `frame_count` increments.
- **Read FSM:**
  - IDLE: stays here until `frame_count != 0` and `rd_ptr != commit_ptr`, then moves to STREAM.
  - STREAM: a prefetch register plus a one-entry skid keep `m00_axis_tvalid` high on every cycle of the frame. Words are read ahead while `m00_axis_tready` is low, without overwriting unconsumed data.
  - On the `tlast` handshake at the output, `frame_count` decrements. The FSM returns to IDLE, or continues directly to the next frame if one is committed.
- **`m00_axis_tvalid`:** never depends combinationally on `m00_axis_tready`. While `tvalid` is high and `tready` is low, `tdata`, `tkeep` and `tlast` hold stable.
- **Simultaneous events:**
  - Commit and output `tlast` in the same cycle: `frame_count` is unchanged.
  - Drop rewind and read in the same cycle: the read is unaffected, because `rd_ptr` never passes `commit_ptr`.
- **Reset mid-operation:** clears all pointers, the count and the FSM. Any partial or stored frames are lost. After reset the upstream source must restart at a frame boundary.

## Timing
- **Reset values:**
  - `s00_axis_tready`=0 during reset; 1 from the first edge after deassertion.
  - `m00_axis_*`=0 and `frame_count`=0.
  - `frame_drop`=0.
- **Commit-to-output latency:** for `tlast` accepted at edge N into an empty buffer, `m00_axis_tvalid` rises after edge N+2 (1 cycle count update, 1 cycle RAM read).
- **Throughput:** 1 word/cycle on each side concurrently. There are no bubble cycles between back-to-back stored frames.
- **`frame_drop`:** asserted for the single cycle after the edge that accepts the dropped frame's `tlast`.

## Configuration
- `TX_FRAME_BUF_KEEP_CHECK_EN` defined: a non-`tlast` beat with `tkeep != 4'b1111`, or a `tlast` beat with `tkeep` of `4'b0000` or non-contiguous, marks the frame bad. A bad frame is discarded exactly like an overflow and pulses `frame_drop`.
- `TX_FRAME_BUF_KEEP_CHECK_EN` undefined: no check is made, and `tkeep` is stored and forwarded unmodified.

## Test plan
- **Basic frame:** a 16-word frame ends with `tkeep`=0011 and `m00_axis_tready`=1. Required: `m00_axis_tvalid` rises 2 cycles after the `tlast` edge; 16 identical words follow with `tvalid` continuous; `frame_count` goes 1→0.
- **Bursty input:** the same frame is sent with `s00_axis_tvalid` low on alternating cycles. Required: output is identical and gap-free, with no `tvalid` low between the first beat and `tlast`.
- **Overflow:** with DEPTH=64, a 70-word frame is followed by a 10-word frame. Required: `frame_drop` pulses once; only the 10-word frame appears at the output; `frame_count` peaks at 1.
- **Output back-pressure:** three back-to-back 15-word frames are sent while `m00_axis_tready` toggles every cycle. Required: data is stable while stalled, order is preserved, and frames are output with no idle cycle between them.
- **Simultaneous commit and release:** frame B's `tlast` is accepted on the same cycle frame A's `tlast` is output. Required: `frame_count` stays at 1, and B streams next.
- **Keep check:** with `TX_FRAME_BUF_KEEP_CHECK_EN` defined, beat 3 of 20 carries `tkeep`=0111. Required: the frame is dropped and `frame_drop` pulses. With the macro undefined, the same frame is forwarded intact.
